// File: rtl/gcore_phase_exec.sv
`default_nettype none
// ============================================================================
// gcore_phase_exec : four-phase fetch/execute/writeback/retire accumulator stage
// Revision 1.0
// ============================================================================
module gcore_phase_exec #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          phase_clk,
    input  logic          acc_write,
    input  logic [DW+3:0] instr,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] acc,
    output logic          zf,
    output logic          cf,
    output logic          retire,
    output logic          seq_err
);

    // Encodings match {phase_clk, acc_write} so the decode is a direct cast.
    typedef enum logic [1:0] {
        PH_R = 2'b00,
        PH_E = 2'b01,
        PH_F = 2'b10,
        PH_W = 2'b11
    } phase_t;

    localparam logic [3:0] OP_LDI = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_JMP = 4'd8;
    localparam logic [3:0] OP_JZ  = 4'd9;
    localparam logic [3:0] OP_JC  = 4'd10;

    localparam logic [AW-1:0] PC_ONE = AW'(1);

    phase_t        exp_q, exp_d;
    phase_t        phase;
    logic [DW+3:0] ir_q, ir_d;
    logic [DW:0]   tmp_q, tmp_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          zf_q, zf_d;
    logic          cf_q, cf_d;
    logic          valid_q, valid_d;
    logic          retire_q, retire_d;
    logic          seq_err_q, seq_err_d;

    logic [3:0]    opcode;
    logic [DW-1:0] imm;
    logic [DW:0]   alu;
    logic          writes_acc;
    logic          take_branch;

    assign phase  = phase_t'({phase_clk, acc_write});
    assign opcode = ir_q[DW+3:DW];
    assign imm    = ir_q[DW-1:0];

    // Bit DW of the result carries carry-out, borrow or the shifted-out bit.
    always_comb begin
        alu = '0;
        case (opcode)
            OP_LDI:  alu = {1'b0, imm};
            OP_ADD:  alu = {1'b0, acc_q} + {1'b0, imm};
            OP_SUB:  alu = {1'b0, acc_q} - {1'b0, imm};
            OP_AND:  alu = {1'b0, acc_q & imm};
            OP_OR:   alu = {1'b0, acc_q | imm};
            OP_XOR:  alu = {1'b0, acc_q ^ imm};
            OP_SHL:  alu = {acc_q, 1'b0};
            default: alu = '0;
        endcase
    end

    assign writes_acc  = (opcode >= OP_LDI) && (opcode <= OP_SHL);
    assign take_branch = (opcode == OP_JMP) ||
                         ((opcode == OP_JZ) && zf_q) ||
                         ((opcode == OP_JC) && cf_q);

    always_comb begin
        exp_d     = exp_q;
        ir_d      = ir_q;
        tmp_d     = tmp_q;
        pc_d      = pc_q;
        acc_d     = acc_q;
        zf_d      = zf_q;
        cf_d      = cf_q;
        valid_d   = valid_q;
        retire_d  = 1'b0;
        seq_err_d = seq_err_q;

        if (phase == PH_F) begin
            // A fetch strobe always resyncs; it is only an error if unexpected.
            ir_d    = instr;
            valid_d = 1'b1;
            exp_d   = PH_E;
            if (exp_q != PH_F) begin
                seq_err_d = 1'b1;
            end
        end else if (phase == exp_q) begin
            case (phase)
                PH_E: begin
                    tmp_d = alu;
                    exp_d = PH_W;
                end
                PH_W: begin
                    if (valid_q && writes_acc) begin
                        acc_d = tmp_q[DW-1:0];
                        zf_d  = (tmp_q[DW-1:0] == '0);
                        if (opcode != OP_LDI) begin
                            cf_d = tmp_q[DW];
                        end
                    end
                    exp_d = PH_R;
                end
                PH_R: begin
                    if (valid_q) begin
                        pc_d     = take_branch ? imm[AW-1:0] : pc_q + PC_ONE;
                        retire_d = 1'b1;
                    end
                    valid_d = 1'b0;
                    exp_d   = PH_F;
                end
                default: ;
            endcase
        end else if (!((phase == PH_R) && (exp_q == PH_F))) begin
            seq_err_d = 1'b1;
            valid_d   = 1'b0;
            exp_d     = PH_F;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            exp_q     <= PH_F;
            ir_q      <= '0;
            tmp_q     <= '0;
            pc_q      <= '0;
            acc_q     <= '0;
            zf_q      <= 1'b0;
            cf_q      <= 1'b0;
            valid_q   <= 1'b0;
            retire_q  <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            exp_q     <= exp_d;
            ir_q      <= ir_d;
            tmp_q     <= tmp_d;
            pc_q      <= pc_d;
            acc_q     <= acc_d;
            zf_q      <= zf_d;
            cf_q      <= cf_d;
            valid_q   <= valid_d;
            retire_q  <= retire_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign pc      = pc_q;
    assign acc     = acc_q;
    assign zf      = zf_q;
    assign cf      = cf_q;
    assign retire  = retire_q;
    assign seq_err = seq_err_q;

endmodule
`default_nettype wire

// File: tb/tb_gcore_phase_exec.sv
`default_nettype none
// ============================================================================
// tb_gcore_phase_exec : directed bench for gcore_phase_exec
// Revision 1.0
// ============================================================================
module tb_gcore_phase_exec;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        phase_clk;
    logic        acc_write;
    logic [11:0] instr;
    logic [7:0]  pc;
    logic [7:0]  acc;
    logic        zf;
    logic        cf;
    logic        retire;
    logic        seq_err;

    logic [11:0] mem [256];

    int n_pass = 0;
    int n_total = 0;
    int cyc_n = 0;
    int ret_cnt = 0;
    int ret_last = 0;
    int ret_gap = 0;

    always #5 clk_in = ~clk_in;

    always_comb instr = mem[pc];

    gcore_phase_exec #(.DW(8), .AW(8)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .phase_clk (phase_clk),
        .acc_write (acc_write),
        .instr     (instr),
        .pc        (pc),
        .acc       (acc),
        .zf        (zf),
        .cf        (cf),
        .retire    (retire),
        .seq_err   (seq_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic cyc(input logic [1:0] ph);
        {phase_clk, acc_write} = ph;
        @(posedge clk_in);
        #1;
        cyc_n++;
        if (retire === 1'b1) begin
            ret_cnt++;
            ret_gap  = cyc_n - ret_last;
            ret_last = cyc_n;
        end
    endtask

    task automatic run_instr();
        cyc(2'b10);
        cyc(2'b01);
        cyc(2'b11);
        cyc(2'b00);
    endtask

    initial begin
        int rc;
        for (int i = 0; i < 256; i++) mem[i] = 12'h000;
        mem[8'h00] = 12'h105;   // LDI 05
        mem[8'h01] = 12'h203;   // ADD 03
        mem[8'h02] = 12'h1FF;   // LDI FF
        mem[8'h03] = 12'h201;   // ADD 01
        mem[8'h04] = 12'h940;   // JZ 40
        mem[8'h40] = 12'h103;   // LDI 03
        mem[8'h41] = 12'h305;   // SUB 05
        mem[8'h42] = 12'hA10;   // JC 10
        mem[8'h10] = 12'h980;   // JZ 80 (not taken)
        mem[8'h11] = 12'h700;   // SHL
        mem[8'h12] = 12'h8FF;   // JMP FF
        mem[8'hFF] = 12'h000;   // NOP

        rst = 1'b1;
        {phase_clk, acc_write} = 2'b00;
        cyc(2'b00);
        cyc(2'b00);
        chk("reset_acc", 32'(acc), 32'h00);
        chk("reset_pc", 32'(pc), 32'h00);
        chk("reset_flags", {30'd0, zf, cf}, 32'd0);
        chk("reset_retire", 32'(retire), 32'd0);
        chk("reset_seq_err", 32'(seq_err), 32'd0);
        rst = 1'b0;

        // LDI 05 step by step for latency
        cyc(2'b10);
        cyc(2'b01);
        chk("ldi_acc_before_w", 32'(acc), 32'h00);
        cyc(2'b11);
        chk("ldi_acc_after_w", 32'(acc), 32'h05);
        chk("ldi_pc_before_r", 32'(pc), 32'h00);
        cyc(2'b00);
        chk("ldi_pc_after_r", 32'(pc), 32'h01);
        chk("ldi_retire", 32'(retire), 32'd1);
        run_instr();            // ADD 03
        chk("add_acc", 32'(acc), 32'h08);
        chk("add_flags", {30'd0, zf, cf}, 32'd0);
        chk("add_pc", 32'(pc), 32'h02);
        chk("retire_count", 32'(ret_cnt), 32'd2);
        chk("retire_gap", 32'(ret_gap), 32'd4);
        cyc(2'b00);
        chk("idle_retire_low", 32'(retire), 32'd0);
        chk("idle_no_seq_err", 32'(seq_err), 32'd0);

        run_instr();            // LDI FF
        run_instr();            // ADD 01
        chk("addwrap_acc", 32'(acc), 32'h00);
        chk("addwrap_cf", 32'(cf), 32'd1);
        chk("addwrap_zf", 32'(zf), 32'd1);
        run_instr();            // JZ 40
        chk("jz_taken_pc", 32'(pc), 32'h40);
        chk("jz_acc_kept", 32'(acc), 32'h00);
        chk("jz_flags_kept", {30'd0, zf, cf}, 32'd3);

        run_instr();            // LDI 03
        chk("ldi_keeps_cf", 32'(cf), 32'd1);
        chk("ldi_clears_zf", 32'(zf), 32'd0);
        run_instr();            // SUB 05
        chk("sub_acc", 32'(acc), 32'hFE);
        chk("sub_borrow", 32'(cf), 32'd1);
        chk("sub_zf", 32'(zf), 32'd0);
        run_instr();            // JC 10
        chk("jc_taken_pc", 32'(pc), 32'h10);
        run_instr();            // JZ 80, zf=0
        chk("jz_not_taken_pc", 32'(pc), 32'h11);
        run_instr();            // SHL
        chk("shl_acc", 32'(acc), 32'hFC);
        chk("shl_cf", 32'(cf), 32'd1);
        run_instr();            // JMP FF
        chk("jmp_pc", 32'(pc), 32'hFF);
        run_instr();            // NOP at FF
        chk("nop_pc_wrap", 32'(pc), 32'h00);
        chk("nop_acc_kept", 32'(acc), 32'hFC);

        // E phase skipped
        mem[8'h00] = 12'h107;   // LDI 07
        rc = ret_cnt;
        cyc(2'b10);
        cyc(2'b11);
        chk("skip_seq_err", 32'(seq_err), 32'd1);
        chk("skip_acc_kept", 32'(acc), 32'hFC);
        cyc(2'b00);
        cyc(2'b00);
        chk("skip_pc_kept", 32'(pc), 32'h00);
        chk("skip_no_retire", 32'(ret_cnt), 32'(rc));
        chk("skip_acc_still", 32'(acc), 32'hFC);
        mem[8'h00] = 12'h201;   // ADD 01
        run_instr();
        chk("resync_acc", 32'(acc), 32'hFD);
        chk("resync_cf", 32'(cf), 32'd0);
        chk("resync_pc", 32'(pc), 32'h01);
        chk("resync_retire", 32'(retire), 32'd1);
        chk("seq_err_sticky", 32'(seq_err), 32'd1);

        // reset during W of LDI AA
        mem[8'h01] = 12'h1AA;
        cyc(2'b10);
        cyc(2'b01);
        rst = 1'b1;
        cyc(2'b11);
        chk("midrst_acc", 32'(acc), 32'h00);
        chk("midrst_pc", 32'(pc), 32'h00);
        chk("midrst_flags", {30'd0, zf, cf}, 32'd0);
        chk("midrst_retire", 32'(retire), 32'd0);
        chk("midrst_seq_err", 32'(seq_err), 32'd0);
        rst = 1'b0;
        cyc(2'b00);
        cyc(2'b00);
        cyc(2'b00);
        chk("post_rst_idle_seq_err", 32'(seq_err), 32'd0);
        chk("post_rst_idle_acc", 32'(acc), 32'h00);
        run_instr();            // ADD 01 at pc 0
        chk("post_rst_acc", 32'(acc), 32'h01);
        chk("post_rst_pc", 32'(pc), 32'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
